// File: rtl/waterfall_light_multi.sv
// N-LED chaser with programmable step period and four display modes (shift-left, shift-right, ping-pong, blink-all).
// Define WATERFALL_LED_ACTIVE_LOW_EN for sink-driven boards (led = ~pattern).
module waterfall_light_multi #(
  parameter int unsigned LED_NUM     = 8,
  parameter int unsigned PERIOD_MAX  = 100_000_000,
  parameter int unsigned PERIOD_STEP = 352_941
) (
  input  logic               clk_100M,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [7:0]         speed,
  input  logic [1:0]         mode,
  output logic [LED_NUM-1:0] led,
  output logic               step_pulse
);

  localparam logic [31:0] P_MAX  = 32'(PERIOD_MAX);
  localparam logic [31:0] P_STEP = 32'(PERIOD_STEP);

  localparam logic [1:0] MODE_LEFT  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_PING  = 2'b10;
  localparam logic [1:0] MODE_BLINK = 2'b11;

  localparam logic [LED_NUM-1:0] PAT_LO  = {{(LED_NUM-1){1'b0}}, 1'b1};
  localparam logic [LED_NUM-1:0] PAT_HI  = {1'b1, {(LED_NUM-1){1'b0}}};
  localparam logic [LED_NUM-1:0] PAT_ALL = {LED_NUM{1'b1}};

  logic [31:0]        r_cnt;
  logic [31:0]        r_period_q;
  logic [LED_NUM-1:0] r_pattern;
  logic               r_dir_up;
  logic [1:0]         r_mode_q;
  logic               r_step_pulse;

  logic [31:0]        w_period_nxt;
  logic               w_step;
  logic [LED_NUM-1:0] w_pattern_nxt;
  logic               w_dir_up_nxt;

  // >= rather than == so a freshly shortened period cannot be overshot into a wrap.
  assign w_period_nxt = P_MAX - (P_STEP * {24'd0, speed});
  assign w_step       = enable && (r_cnt >= (r_period_q - 32'd1));

  always_comb begin
    w_pattern_nxt = r_pattern;
    w_dir_up_nxt  = r_dir_up;
    if (mode != r_mode_q) begin
      case (mode)
        MODE_LEFT: begin
          w_pattern_nxt = PAT_LO;
          w_dir_up_nxt  = 1'b1;
        end
        MODE_RIGHT: w_pattern_nxt = PAT_HI;
        MODE_PING: begin
          w_pattern_nxt = PAT_LO;
          w_dir_up_nxt  = 1'b1;
        end
        MODE_BLINK: w_pattern_nxt = PAT_ALL;
      endcase
    end else begin
      case (r_mode_q)
        MODE_LEFT:  w_pattern_nxt = {r_pattern[LED_NUM-2:0], r_pattern[LED_NUM-1]};
        MODE_RIGHT: w_pattern_nxt = {r_pattern[0], r_pattern[LED_NUM-1:1]};
        MODE_PING: begin
          // Turn around on the end bit itself so each end is lit for a single step.
          if (r_dir_up) begin
            if (r_pattern[LED_NUM-1]) begin
              w_dir_up_nxt  = 1'b0;
              w_pattern_nxt = r_pattern >> 1;
            end else begin
              w_pattern_nxt = r_pattern << 1;
            end
          end else begin
            if (r_pattern[0]) begin
              w_dir_up_nxt  = 1'b1;
              w_pattern_nxt = r_pattern << 1;
            end else begin
              w_pattern_nxt = r_pattern >> 1;
            end
          end
        end
        MODE_BLINK: w_pattern_nxt = ~r_pattern;
      endcase
    end
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= 32'd0;
      r_period_q   <= P_MAX;
      r_pattern    <= PAT_LO;
      r_dir_up     <= 1'b1;
      r_mode_q     <= MODE_LEFT;
      r_step_pulse <= 1'b0;
    end else begin
      r_step_pulse <= w_step;
      if (w_step) begin
        r_cnt      <= 32'd0;
        r_period_q <= w_period_nxt;
        r_pattern  <= w_pattern_nxt;
        r_dir_up   <= w_dir_up_nxt;
        r_mode_q   <= mode;
      end else if (enable) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign step_pulse = r_step_pulse;

`ifdef WATERFALL_LED_ACTIVE_LOW_EN
  assign led = ~r_pattern;
`else
  assign led = r_pattern;
`endif

endmodule

// File: tb/tb_waterfall_light_multi.sv
// Directed bench for waterfall_light_multi with LED_NUM=4, PERIOD_MAX=300, PERIOD_STEP=1.
module tb_waterfall_light_multi;

  logic       clk_100M = 1'b0;
  logic       rst_n    = 1'b0;
  logic       enable   = 1'b0;
  logic [7:0] speed    = 8'd0;
  logic [1:0] mode     = 2'b00;
  logic [3:0] led;
  logic       step_pulse;

  int total = 0;
  int bad   = 0;
  int gap;
  int pulses;

  always #5 clk_100M = ~clk_100M;

  waterfall_light_multi #(
    .LED_NUM    (4),
    .PERIOD_MAX (300),
    .PERIOD_STEP(1)
  ) dut (
    .clk_100M  (clk_100M),
    .rst_n     (rst_n),
    .enable    (enable),
    .speed     (speed),
    .mode      (mode),
    .led       (led),
    .step_pulse(step_pulse)
  );

  function automatic logic [3:0] exp_led(input logic [3:0] p);
`ifdef WATERFALL_LED_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_100M);
      #1;
    end
  endtask

  // Counts edges up to and including the one that raises step_pulse; bounded.
  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(posedge clk_100M);
      #1;
      n++;
    end while (!step_pulse && n < 2000);
  endtask

  task automatic step_check(input string tag, input int exp_gap, input logic [3:0] exp_pat);
    int k;
    wait_step(k);
    check({tag, "_gap"}, k, exp_gap);
    check({tag, "_led"}, {28'd0, led}, {28'd0, exp_led(exp_pat)});
  endtask

  initial begin
    enable = 1'b1;
    tick(3);
    check("rst_led", {28'd0, led}, {28'd0, exp_led(4'b0001)});
    check("rst_pulse", {31'd0, step_pulse}, 32'd0);

    // Shift-left from reset.
    rst_n = 1'b1;
    step_check("sl1", 300, 4'b0010);
    tick(1);
    check("pulse_one_cycle", {31'd0, step_pulse}, 32'd0);
    step_check("sl2", 299, 4'b0100);
    step_check("sl3", 300, 4'b1000);
    step_check("sl4", 300, 4'b0001);

    // Speed raised mid-period: current period unchanged, then 45-cycle spacing.
    tick(100);
    speed = 8'd255;
    step_check("spd1", 200, 4'b0010);
    step_check("spd2", 45, 4'b0100);
    step_check("spd3", 45, 4'b1000);
    speed = 8'd0;
    step_check("spd4", 45, 4'b0001);
    step_check("spd5", 300, 4'b0010);
    step_check("spd6", 300, 4'b0100);

    // Blink-all, then shift-right.
    mode = 2'b11;
    step_check("bl1", 300, 4'b1111);
    step_check("bl2", 300, 4'b0000);
    step_check("bl3", 300, 4'b1111);
    mode = 2'b01;
    step_check("sr1", 300, 4'b1000);
    step_check("sr2", 300, 4'b0100);

    // Freeze at cnt = 150 for 1000 cycles.
    tick(150);
    enable = 1'b0;
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk_100M);
      #1;
      if (step_pulse) pulses++;
      if (led !== exp_led(4'b0100)) pulses++;
    end
    check("freeze_activity", pulses, 0);
    enable = 1'b1;
    step_check("resume", 150, 4'b0010);

    // Ping-pong from reset.
    mode  = 2'b10;
    rst_n = 1'b0;
    tick(2);
    check("rst2_led", {28'd0, led}, {28'd0, exp_led(4'b0001)});
    rst_n = 1'b1;
    step_check("pp1", 300, 4'b0001);
    step_check("pp2", 300, 4'b0010);
    step_check("pp3", 300, 4'b0100);
    step_check("pp4", 300, 4'b1000);
    step_check("pp5", 300, 4'b0100);
    step_check("pp6", 300, 4'b0010);
    step_check("pp7", 300, 4'b0001);
    step_check("pp8", 300, 4'b0010);
    step_check("pp9", 300, 4'b0100);
    step_check("pp10", 300, 4'b1000);
    step_check("pp11", 300, 4'b0100);

    // Asynchronous reset mid-period with dir = down.
    tick(100);
    rst_n = 1'b0;
    #2;
    check("async_led", {28'd0, led}, {28'd0, exp_led(4'b0001)});
    check("async_pulse", {31'd0, step_pulse}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    step_check("ar1", 300, 4'b0001);
    step_check("ar2", 300, 4'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
